// File: rtl/armleocpu_fetch_cache_if.sv
// Fetch<->cache command bundle plus single-beat AR/R refill channel.
// slave: cache side; master: fetch unit and memory fabric side.
`ifndef CACHE_CMD_NONE
`define CACHE_CMD_NONE           4'd0
`define CACHE_CMD_EXECUTE        4'd1
`define CACHE_CMD_FLUSH_ALL      4'd4
`define CACHE_RESPONSE_SUCCESS     4'd0
`define CACHE_RESPONSE_ACCESSFAULT 4'd1
`define CACHE_RESPONSE_MISSALIGNED 4'd3
`endif

interface armleocpu_fetch_cache_if;
  logic [3:0]  c_cmd;
  logic [31:0] c_address;
  logic        c_done;
  logic [3:0]  c_response;
  logic [31:0] c_load_data;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_araddr;
  logic        m_rvalid;
  logic        m_rready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;

  modport slave (
    input  c_cmd, c_address,
    input  m_arready, m_rvalid, m_rdata, m_rresp,
    output c_done, c_response, c_load_data,
    output m_arvalid, m_araddr, m_rready
  );

  modport master (
    output c_cmd, c_address,
    output m_arready, m_rvalid, m_rdata, m_rresp,
    input  c_done, c_response, c_load_data,
    input  m_arvalid, m_araddr, m_rready
  );
endinterface

// File: rtl/armleocpu_fetch_cache.sv
// Direct-mapped one-word-per-line instruction cache, single-beat refill.
// Ports: clk, rst_n (sync, active-low), bus (armleocpu_fetch_cache_if.slave).
`ifndef CACHE_CMD_NONE
`define CACHE_CMD_NONE           4'd0
`define CACHE_CMD_EXECUTE        4'd1
`define CACHE_CMD_FLUSH_ALL      4'd4
`define CACHE_RESPONSE_SUCCESS     4'd0
`define CACHE_RESPONSE_ACCESSFAULT 4'd1
`define CACHE_RESPONSE_MISSALIGNED 4'd3
`endif

module armleocpu_fetch_cache #(
  parameter int LINES_W = 6
) (
  input logic clk,
  input logic rst_n,
  armleocpu_fetch_cache_if.slave bus
);
  localparam int LINES = 1 << LINES_W;
  localparam int TAG_W = 30 - LINES_W;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, REFILL_AR, REFILL_R, FLUSH
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic [LINES_W-1:0]  cnt_q, cnt_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic                c_done_q, c_done_d;
  logic [3:0]          c_response_q, c_response_d;
  logic [31:0]         c_load_data_q, c_load_data_d;
  logic                m_arvalid_q, m_arvalid_d;
  logic [31:0]         m_araddr_q, m_araddr_d;
  logic                m_rready_q, m_rready_d;

  logic [TAG_W-1:0]    tag_mem [LINES];
  logic [31:0]         data_mem [LINES];
  logic [TAG_W-1:0]    rd_tag_q;
  logic [31:0]         rd_data_q;
  logic                mem_re, mem_we;

  logic [LINES_W-1:0]  req_idx, idx;
  logic [TAG_W-1:0]    tag;

  assign req_idx = bus.c_address[LINES_W+1:2];
  assign idx     = addr_q[LINES_W+1:2];
  assign tag     = addr_q[31:LINES_W+2];

  assign bus.c_done      = c_done_q;
  assign bus.c_response  = c_response_q;
  assign bus.c_load_data = c_load_data_q;
  assign bus.m_arvalid   = m_arvalid_q;
  assign bus.m_araddr    = m_araddr_q;
  assign bus.m_rready    = m_rready_q;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    valid_d       = valid_q;
    c_done_d      = 1'b0;
    c_response_d  = c_response_q;
    c_load_data_d = c_load_data_q;
    m_arvalid_d   = m_arvalid_q;
    m_araddr_d    = m_araddr_q;
    m_rready_d    = m_rready_q;
    mem_re        = 1'b0;
    mem_we        = 1'b0;
    unique case (state_q)
      IDLE: begin
        // The done cycle still carries the finished command; skip it.
        if (!c_done_q) begin
          unique case (1'b1)
            bus.c_cmd == `CACHE_CMD_EXECUTE: begin
              addr_d  = bus.c_address;
              mem_re  = 1'b1;
              state_d = LOOKUP;
            end
            bus.c_cmd == `CACHE_CMD_FLUSH_ALL: begin
              cnt_d   = '0;
              state_d = FLUSH;
            end
            default: ;
          endcase
        end
      end
      LOOKUP: begin
        if (addr_q[1:0] != 2'b00) begin
          c_done_d     = 1'b1;
          c_response_d = `CACHE_RESPONSE_MISSALIGNED;
          state_d      = IDLE;
        end else if (valid_q[idx] && rd_tag_q == tag) begin
          c_done_d      = 1'b1;
          c_response_d  = `CACHE_RESPONSE_SUCCESS;
          c_load_data_d = rd_data_q;
          state_d       = IDLE;
        end else begin
          m_arvalid_d = 1'b1;
          m_araddr_d  = {addr_q[31:2], 2'b00};
          state_d     = REFILL_AR;
        end
      end
      REFILL_AR: begin
        if (bus.m_arready) begin
          m_arvalid_d = 1'b0;
          m_rready_d  = 1'b1;
          state_d     = REFILL_R;
        end
      end
      REFILL_R: begin
        if (bus.m_rvalid) begin
          m_rready_d = 1'b0;
          c_done_d   = 1'b1;
          state_d    = IDLE;
          if (bus.m_rresp == 2'b00) begin
            mem_we        = 1'b1;
            valid_d[idx]  = 1'b1;
            c_response_d  = `CACHE_RESPONSE_SUCCESS;
            c_load_data_d = bus.m_rdata;
          end else begin
            c_response_d = `CACHE_RESPONSE_ACCESSFAULT;
          end
        end
      end
      FLUSH: begin
        valid_d[cnt_q] = 1'b0;
        cnt_d          = cnt_q + LINES_W'(1);
        if (cnt_q == '1) begin
          c_done_d     = 1'b1;
          c_response_d = `CACHE_RESPONSE_SUCCESS;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      cnt_q         <= '0;
      valid_q       <= '0;
      c_done_q      <= 1'b0;
      c_response_q  <= `CACHE_RESPONSE_SUCCESS;
      c_load_data_q <= '0;
      m_arvalid_q   <= 1'b0;
      m_araddr_q    <= '0;
      m_rready_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      valid_q       <= valid_d;
      c_done_q      <= c_done_d;
      c_response_q  <= c_response_d;
      c_load_data_q <= c_load_data_d;
      m_arvalid_q   <= m_arvalid_d;
      m_araddr_q    <= m_araddr_d;
      m_rready_q    <= m_rready_d;
    end
  end

  // Arrays carry no reset; valid_q alone decides whether a line is live.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= bus.m_rdata;
    end
    if (mem_re) begin
      rd_tag_q  <= tag_mem[req_idx];
      rd_data_q <= data_mem[req_idx];
    end
  end
endmodule

// File: tb/tb_armleocpu_fetch_cache.sv
// Directed bench for armleocpu_fetch_cache with a single-beat memory responder.
// Latency n counts clock edges from command presentation to visible c_done.
module tb_armleocpu_fetch_cache;
  localparam int LINES_W = 6;
  localparam logic [3:0] NONE = 4'd0;
  localparam logic [3:0] EXEC = 4'd1;
  localparam logic [3:0] FLSH = 4'd4;
  localparam logic [3:0] OK   = 4'd0;
  localparam logic [3:0] AF   = 4'd1;
  localparam logic [3:0] MA   = 4'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  armleocpu_fetch_cache_if bus ();

  armleocpu_fetch_cache #(.LINES_W(LINES_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h1000) ? 32'h0000_0013 : (a ^ 32'h5A5A_0000);
  endfunction

  int          ar_delay  = 0;
  logic [1:0]  rresp_cfg = 2'b00;
  bit          r_hold    = 1'b0;
  int          ar_count  = 0;

  initial begin
    bit ar_hs, r_hs, arv_prev, rr_prev, pend;
    logic [31:0] addr_prev, paddr;
    int wc;
    arv_prev = 0; rr_prev = 0; pend = 0; wc = 0;
    addr_prev = '0; paddr = '0;
    bus.m_arready = 1'b0;
    bus.m_rvalid  = 1'b0;
    bus.m_rdata   = '0;
    bus.m_rresp   = 2'b00;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        bus.m_arready = 1'b0;
        bus.m_rvalid  = 1'b0;
        pend = 0;
        wc = 0;
      end else begin
        ar_hs = arv_prev && bus.m_arready;
        r_hs  = rr_prev && bus.m_rvalid;
        if (r_hs) bus.m_rvalid = 1'b0;
        if (ar_hs) begin
          bus.m_arready = 1'b0;
          pend  = 1;
          paddr = addr_prev;
          wc    = 0;
          ar_count++;
        end
        if (pend && !r_hold && !bus.m_rvalid) begin
          bus.m_rvalid = 1'b1;
          bus.m_rdata  = mem_word(paddr);
          bus.m_rresp  = rresp_cfg;
          pend = 0;
        end
        if (bus.m_arvalid && !bus.m_arready) begin
          if (wc >= ar_delay) bus.m_arready = 1'b1;
          else wc++;
        end
      end
      arv_prev  = bus.m_arvalid;
      rr_prev   = bus.m_rready;
      addr_prev = bus.m_araddr;
    end
  end

  task automatic run_cmd(input logic [3:0] cmd, input logic [31:0] addr,
                         output logic [3:0] resp, output logic [31:0] data,
                         output int n, output bit saw_ar);
    bit got;
    @(posedge clk);
    #1;
    bus.c_cmd = cmd;
    bus.c_address = addr;
    n = 0;
    got = 0;
    saw_ar = 0;
    while (n < 200 && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.m_arvalid) saw_ar = 1;
      if (bus.c_done) got = 1;
    end
    resp = bus.c_response;
    data = bus.c_load_data;
    bus.c_cmd = NONE;
    if (!got) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic exec_chk(input string tag, input logic [31:0] addr,
                          input logic [3:0] exp_resp,
                          input logic [31:0] exp_data,
                          input int exp_n, input int exp_ar);
    logic [3:0] resp;
    logic [31:0] data;
    int n, a0;
    bit saw;
    a0 = ar_count;
    run_cmd(EXEC, addr, resp, data, n, saw);
    #2;
    check({tag, ".resp"}, 32'(resp), 32'(exp_resp));
    if (exp_resp == OK) check({tag, ".data"}, data, exp_data);
    check({tag, ".lat"}, n, exp_n);
    check({tag, ".ar"}, ar_count - a0, exp_ar);
    check({tag, ".arv"}, 32'(saw), 32'(exp_ar != 0));
  endtask

  task automatic chk_reset_outs(input string tag);
    check({tag, ".done"}, 32'(bus.c_done), 32'd0);
    check({tag, ".resp"}, 32'(bus.c_response), 32'(OK));
    check({tag, ".ldata"}, bus.c_load_data, 32'd0);
    check({tag, ".arvalid"}, 32'(bus.m_arvalid), 32'd0);
    check({tag, ".rready"}, 32'(bus.m_rready), 32'd0);
    check({tag, ".araddr"}, bus.m_araddr, 32'd0);
  endtask

  initial begin
    logic [3:0] resp;
    logic [31:0] data;
    logic [31:0] addr0;
    int n, a0;
    bit saw, bad, seen;
    bus.c_cmd = NONE;
    bus.c_address = '0;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("reset");
    rst_n = 1'b1;

    exec_chk("t1_miss", 32'h1000, OK, 32'h13, 4, 1);
    exec_chk("t1_hit",  32'h1000, OK, 32'h13, 2, 0);

    exec_chk("t2_mis", 32'h1002, MA, 32'h0, 2, 0);

    rresp_cfg = 2'd2;
    exec_chk("t3_fault", 32'h2000, AF, 32'h0, 4, 1);
    rresp_cfg = 2'd0;
    exec_chk("t3_retry", 32'h2000, OK, 32'h5A5A_2000, 4, 1);
    exec_chk("t3_hit",   32'h2000, OK, 32'h5A5A_2000, 2, 0);

    exec_chk("t4_alias", 32'h1100, OK, 32'h5A5A_1100, 4, 1);
    exec_chk("t4_evict", 32'h1000, OK, 32'h13, 4, 1);
    exec_chk("t4_again", 32'h1100, OK, 32'h5A5A_1100, 4, 1);

    exec_chk("t5_f0", 32'h3000, OK, 32'h5A5A_3000, 4, 1);
    exec_chk("t5_f1", 32'h3004, OK, 32'h5A5A_3004, 4, 1);
    exec_chk("t5_f2", 32'h3008, OK, 32'h5A5A_3008, 4, 1);
    exec_chk("t5_h1", 32'h3004, OK, 32'h5A5A_3004, 2, 0);
    a0 = ar_count;
    run_cmd(FLSH, 32'h0, resp, data, n, saw);
    check("t5_flush.resp", 32'(resp), 32'(OK));
    check("t5_flush.lat", n, (1 << LINES_W) + 1);
    check("t5_flush.ar", ar_count - a0, 0);
    exec_chk("t5_r0", 32'h3000, OK, 32'h5A5A_3000, 4, 1);
    exec_chk("t5_r1", 32'h3004, OK, 32'h5A5A_3004, 4, 1);
    exec_chk("t5_r2", 32'h3008, OK, 32'h5A5A_3008, 4, 1);

    @(posedge clk);
    #1;
    bus.c_cmd = 4'hF;
    bad = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.c_done || bus.m_arvalid) bad = 1;
    end
    bus.c_cmd = NONE;
    check("unknown_cmd", 32'(bad), 32'd0);

    exec_chk("t6_fill", 32'h1000, OK, 32'h13, 4, 1);
    exec_chk("t6_hit",  32'h1000, OK, 32'h13, 2, 0);
    ar_delay = 5;
    r_hold = 1'b1;
    @(posedge clk);
    #1;
    bus.c_cmd = EXEC;
    bus.c_address = 32'h4000;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (bus.m_arvalid) seen = 1;
    end
    check("t6_arvalid", 32'(seen), 32'd1);
    addr0 = bus.m_araddr;
    check("t6_araddr", addr0, 32'h4000);
    bad = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (!bus.m_arvalid || bus.m_araddr != addr0) bad = 1;
    end
    check("t6_ar_stable", 32'(bad), 32'd0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (bus.m_rready) seen = 1;
    end
    check("t6_in_refill_r", 32'(seen), 32'd1);
    rst_n = 1'b0;
    bus.c_cmd = NONE;
    @(posedge clk);
    #1;
    chk_reset_outs("t6_rst");
    rst_n = 1'b1;
    r_hold = 1'b0;
    ar_delay = 0;
    exec_chk("t6_after", 32'h1000, OK, 32'h13, 4, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
